// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter: FSM state encoding and a
// constant-width helper used to size counters and pointers.
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_e;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority search: first set request at or above ptr, wrapping
// modulo NREQ. Purely combinational.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] pick,
    output logic            valid
);

    logic [PW-1:0] idx;

    always_comb begin
        pick  = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PW'((int'(ptr) + k) % NREQ);
            if (!valid && req[idx]) begin
                pick[idx] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter feeding one FIFO write port from NREQ requesters.
// Optional stall counter output enabled by FIFO_WR_ARB_STALL_CNT_EN.
//
//   state | meaning
//   IDLE  | no owner; gnt = 0; pick next requester from ptr
//   OWN   | one requester owns the port until BURST words or req drops
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8,
    parameter int BURST = 4
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*DSIZE-1:0] wdata_in,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    input  logic                  wfull,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic                  busy
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);

    localparam int PW = clog2(NREQ);
    localparam int BW = clog2(BURST + 1);
    localparam logic [BW-1:0] BURST_C = BW'(BURST);
    localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

    arb_state_e      state_q;
    logic [NREQ-1:0] gnt_q;
    logic [BW-1:0]   beat_q;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   owner_q;

    logic [NREQ-1:0] pick;
    logic            pick_valid;
    logic [PW-1:0]   pick_idx;
    logic [PW-1:0]   ptr_d;
    logic [BW-1:0]   beat_d;
    logic            owner_req;
    logic            accept;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr_q),
        .pick  (pick),
        .valid (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick[i]) begin
                pick_idx = PW'(i);
            end
        end
    end

    // gnt is zero outside OWN, so ack/wdata need no separate state qualifier
    assign ack       = gnt_q & req & {NREQ{~wfull}};
    assign winc      = |ack;
    assign accept    = winc;
    assign owner_req = |(gnt_q & req);
    assign beat_d    = beat_q + 1'b1;
    assign ptr_d     = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
    assign gnt       = gnt_q;
    assign busy      = (state_q == ST_OWN);

    always_comb begin
        wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) begin
                wdata = wdata_in[i*DSIZE +: DSIZE];
            end
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            beat_q  <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state_q <= ST_OWN;
                        gnt_q   <= pick;
                        owner_q <= pick_idx;
                        beat_q  <= '0;
                    end
                end
                ST_OWN: begin
                    if (!owner_req || (accept && beat_d == BURST_C)) begin
                        state_q <= ST_IDLE;
                        gnt_q   <= '0;
                        beat_q  <= '0;
                        ptr_q   <= ptr_d;
                    end else if (accept) begin
                        beat_q <= beat_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

`ifdef FIFO_WR_ARB_STALL_CNT_EN
    logic [15:0] stall_q;
    logic [15:0] stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == ST_OWN && owner_req && wfull && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Scoreboard bench for fifo_wr_arb: directed arbitration scenarios followed by
// randomized traffic, checked against a queue-based requester/arbiter model.
module tb_fifo_wr_arb;

    localparam int NREQ  = 4;
    localparam int DSIZE = 8;
    localparam int BURST = 4;

    logic                  wclk = 1'b0;
    logic                  wrst;
    logic [NREQ-1:0]       req;
    logic [NREQ*DSIZE-1:0] wdata_in;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic                  wfull;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic                  busy;
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    logic [15:0]           stall_cnt;
`endif

    fifo_wr_arb #(
        .NREQ  (NREQ),
        .DSIZE (DSIZE),
        .BURST (BURST)
    ) dut (
        .wclk      (wclk),
        .wrst      (wrst),
        .req       (req),
        .wdata_in  (wdata_in),
        .gnt       (gnt),
        .ack       (ack),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .busy      (busy)
`ifdef FIFO_WR_ARB_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 wclk = ~wclk;

    typedef struct {
        logic [NREQ-1:0]  gnt;
        logic [NREQ-1:0]  ack;
        logic [DSIZE-1:0] wdata;
        int               stall;
    } exp_t;

    exp_t             exp_q[$];
    logic [DSIZE-1:0] wr_q[$];
    logic [DSIZE-1:0] src_q[NREQ][$];
    int               grant_log[$];
    int               wr_per_grant[$];

    int n_cmp  = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    // Reference model: owner index (-1 = nobody), words taken this grant, rotation start
    int m_owner = -1;
    int m_beats = 0;
    int m_ptr   = 0;
    int m_stall = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic bit bitof(input logic [NREQ-1:0] v, input int i);
        return ((v >> i) & NREQ'(1)) != '0;
    endfunction

    task automatic load(input int i, input int n);
        for (int k = 0; k < n; k++) begin
            src_q[i].push_back(DSIZE'($urandom));
        end
    endtask

    task automatic step(input bit rst, input bit full);
        logic [NREQ-1:0] r;
        logic [NREQ-1:0] mack;
        exp_t            e;
        bit              own_req;
        r = '0;
        for (int i = 0; i < NREQ; i++) begin
            r[i] = (src_q[i].size() > 0);
            wdata_in[i*DSIZE +: DSIZE] = r[i] ? src_q[i][0] : DSIZE'($urandom);
        end
        req   = r;
        wfull = full;
        wrst  = rst;

        own_req = (m_owner >= 0) && bitof(r, m_owner);
        mack    = '0;
        if (own_req && !full) mack = NREQ'(1) << m_owner;
        e.gnt   = (m_owner >= 0) ? (NREQ'(1) << m_owner) : '0;
        e.ack   = mack;
        e.wdata = (m_owner >= 0) ? DSIZE'(wdata_in >> (m_owner * DSIZE)) : '0;
        e.stall = m_stall;
        exp_q.push_back(e);
        if (mack != '0) wr_q.push_back(src_q[m_owner][0]);

        @(posedge wclk);
        if (own_req && full && m_stall < 65535) m_stall++;
        if (mack != '0) begin
            void'(src_q[m_owner].pop_front());
            m_beats++;
        end
        if (rst) begin
            m_owner = -1;
            m_beats = 0;
            m_ptr   = 0;
            m_stall = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < NREQ; k++) begin
                int c;
                c = (m_ptr + k) % NREQ;
                if (m_owner < 0 && bitof(r, c)) begin
                    m_owner = c;
                    m_beats = 0;
                end
            end
        end else if (!own_req || m_beats == BURST) begin
            m_ptr   = (m_owner + 1) % NREQ;
            m_owner = -1;
        end
        #1;
    endtask

    task automatic scen_start();
        for (int i = 0; i < NREQ; i++) src_q[i].delete();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        grant_log.delete();
        wr_per_grant.delete();
    endtask

    // Monitor: pops one expectation per cycle, and one expected word per write
    exp_t            mon_e;
    logic [NREQ-1:0] prev_gnt = '0;
    int              cur_wr   = 0;

    always @(negedge wclk) begin
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL scoreboard_underrun: got output cycle, expected none");
            end else begin
                mon_e = exp_q.pop_front();
                check("gnt", 32'(gnt), 32'(mon_e.gnt));
                check("ack", 32'(ack), 32'(mon_e.ack));
                check("winc", 32'(winc), 32'(mon_e.ack != '0));
                check("busy", 32'(busy), 32'(mon_e.gnt != '0));
                check("wdata", 32'(wdata), 32'(mon_e.wdata));
`ifdef FIFO_WR_ARB_STALL_CNT_EN
                check("stall_cnt", 32'(stall_cnt), 32'(mon_e.stall));
`endif
            end
            if (gnt != '0 && prev_gnt == '0) begin
                cur_wr = 0;
                for (int i = 0; i < NREQ; i++) begin
                    if (gnt[i]) grant_log.push_back(i);
                end
            end
            if (winc === 1'b1) begin
                cur_wr++;
                if (wr_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_write: got word %0h, expected no write", wdata);
                end else begin
                    check("write_word", 32'(wdata), 32'(wr_q.pop_front()));
                end
            end
            if (gnt == '0 && prev_gnt != '0) wr_per_grant.push_back(cur_wr);
            prev_gnt = gnt;
        end
    end

    initial begin
        wrst     = 1'b1;
        wfull    = 1'b0;
        req      = '0;
        wdata_in = '0;
        repeat (2) @(posedge wclk);
        #1;
        check("reset_gnt", 32'(gnt), 32'h0);
        check("reset_ack", 32'(ack), 32'h0);
        check("reset_winc", 32'(winc), 32'h0);
        check("reset_wdata", 32'(wdata), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
`ifdef FIFO_WR_ARB_STALL_CNT_EN
        check("reset_stall", 32'(stall_cnt), 32'h0);
`endif
        mon_en = 1'b1;

        // Single requester: 4-word burst, bubble, re-grant
        scen_start();
        load(0, 5);
        repeat (12) step(1'b0, 1'b0);
        check("s1_ngrant", 32'(grant_log.size()), 32'd2);
        check("s1_g0", 32'(grant_log[0]), 32'd0);
        check("s1_g1", 32'(grant_log[1]), 32'd0);
        check("s1_burst", 32'(wr_per_grant[0]), 32'd4);

        // All requesting: rotation 0,1,2,3,0 with full bursts
        scen_start();
        load(0, 8);
        for (int i = 1; i < NREQ; i++) load(i, 4);
        repeat (30) step(1'b0, 1'b0);
        check("s2_ngrant", 32'(grant_log.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check("s2_order", 32'(grant_log[i]), 32'(i % NREQ));
            check("s2_burst", 32'(wr_per_grant[i]), 32'd4);
        end

        // Owner 2 stalled by wfull for 10 cycles after one beat
        scen_start();
        load(2, 4);
        repeat (2) step(1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b1);
        check("s3_gnt_stalled", 32'(gnt), 32'h4);
`ifdef FIFO_WR_ARB_STALL_CNT_EN
        check("s3_stall", 32'(stall_cnt), 32'd10);
`endif
        repeat (6) step(1'b0, 1'b0);
        check("s3_grant", 32'(grant_log[0]), 32'd2);
        check("s3_burst", 32'(wr_per_grant[0]), 32'd4);

        // Owner 1 drops early; pointer moves to 2 so requester 0 wins next
        scen_start();
        load(1, 2);
        repeat (4) step(1'b0, 1'b0);
        load(0, 2);
        load(1, 2);
        repeat (10) step(1'b0, 1'b0);
        check("s4_ngrant", 32'(grant_log.size()), 32'd3);
        check("s4_g0", 32'(grant_log[0]), 32'd1);
        check("s4_g1", 32'(grant_log[1]), 32'd0);
        check("s4_g2", 32'(grant_log[2]), 32'd1);
        check("s4_burst0", 32'(wr_per_grant[0]), 32'd2);

        // Reset mid-burst aborts the grant
        scen_start();
        load(0, 6);
        load(2, 3);
        repeat (3) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        check("s5_gnt_after_rst", 32'(gnt), 32'h0);
        check("s5_winc_after_rst", 32'(winc), 32'h0);
        repeat (8) step(1'b0, 1'b0);
        check("s5_g0", 32'(grant_log[0]), 32'd0);
        check("s5_g1", 32'(grant_log[1]), 32'd0);

        // Randomized traffic with occasional resets, then drain
        scen_start();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (src_q[i].size() == 0 && $urandom_range(0, 3) == 0) begin
                    load(i, int'($urandom_range(1, 7)));
                end
            end
            step($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0);
        end
        repeat (60) step(1'b0, 1'b0);
        mon_en = 1'b0;
        check("end_exp_backlog", 32'(exp_q.size()), 32'd0);
        check("end_write_backlog", 32'(wr_q.size()), 32'd0);
        check("end_idle", 32'(busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
